// File: rtl/fifo_write_control.sv
// fifo_write_control: write-side pointer, Gray sync and full/level flags for a 128-entry async FIFO
module fifo_write_control #(
  parameter int ALMOST_FULL_THRESHOLD = 120
) (
  input  logic       clock_write,
  input  logic       reset_write,
  input  logic       write_request,
  input  logic [7:0] read_pointer_gray,
  output logic       write_enable,
  output logic [6:0] write_address,
  output logic [7:0] write_pointer_gray,
  output logic       full,
  output logic       almost_full,
  output logic [7:0] write_level,
  output logic       overflow_error
);
  localparam logic [7:0] af_level = 8'(ALMOST_FULL_THRESHOLD);
  logic [7:0] bin_ptr, next_bin, next_gray, sync1, sync2, read_bin, next_level;
  assign write_enable = write_request & ~full;
  assign write_address = bin_ptr[6:0];
  always_comb begin
    next_bin = bin_ptr + {7'd0, write_enable};
    next_gray = (next_bin >> 1) ^ next_bin;
    for (int i = 0; i < 8; i++) read_bin[i] = ^(sync2 >> i);
    next_level = next_bin - read_bin;
  end
  always_ff @(posedge clock_write) begin
    if (reset_write) begin
      bin_ptr <= '0;
      write_pointer_gray <= '0;
      sync1 <= '0;
      sync2 <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      write_level <= '0;
      overflow_error <= 1'b0;
    end else begin
      bin_ptr <= next_bin;
      write_pointer_gray <= next_gray;
      sync1 <= read_pointer_gray;
      sync2 <= sync1;
      full <= next_gray == {~sync2[7:6], sync2[5:0]};
      almost_full <= next_level >= af_level;
      write_level <= next_level;
      overflow_error <= overflow_error | (write_request & full);
    end
  end
endmodule

// File: tb/tb_fifo_write_control.sv
// tb_fifo_write_control: scoreboard bench; driver pushes per-cycle expectations, monitor checks after each edge
module tb_fifo_write_control;
  logic clock_write = 0, reset_write = 0, write_request = 0;
  logic [7:0] read_pointer_gray = 0;
  logic write_enable, full, almost_full, overflow_error;
  logic [6:0] write_address;
  logic [7:0] write_pointer_gray, write_level;

  fifo_write_control #(.ALMOST_FULL_THRESHOLD(120)) dut (
    .clock_write(clock_write), .reset_write(reset_write), .write_request(write_request),
    .read_pointer_gray(read_pointer_gray), .write_enable(write_enable),
    .write_address(write_address), .write_pointer_gray(write_pointer_gray), .full(full),
    .almost_full(almost_full), .write_level(write_level), .overflow_error(overflow_error));

  always #5 clock_write = ~clock_write;

  typedef struct {
    bit we, rst;
    logic [6:0] addr;
    logic [7:0] gray, lvl;
    bit full, af, ovf;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: counts writes, delays read pointer by two syncs
  logic [7:0] m_w = 0, m_s1 = 0, m_s2 = 0, m_lvl = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, m_we = 0;

  task automatic step(input bit req, input bit rst, input int rbv);
    exp_t e;
    logic [7:0] rb;
    rb = 8'(rbv);
    @(negedge clock_write);
    write_request = req;
    reset_write = rst;
    read_pointer_gray = rb ^ (rb >> 1);
    e.we = req && !m_full;
    e.rst = rst;
    e.addr = m_w[6:0];
    m_we = e.we;
    if (rst) begin
      m_w = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (req && m_full) m_ovf = 1;
      if (e.we) m_w = m_w + 8'd1;
      m_lvl = m_w - m_s2;
      m_full = m_lvl == 8'd128;
      m_af = m_lvl >= 8'd120;
      m_s2 = m_s1;
      m_s1 = rb;
    end
    e.gray = m_w ^ (m_w >> 1);
    e.lvl = m_lvl;
    e.full = m_full;
    e.af = m_af;
    e.ovf = m_ovf;
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clock_write);
    #2;
  endtask

  logic we_s;
  logic [6:0] addr_s;
  logic [7:0] prev_g = 0;
  always @(posedge clock_write) begin
    we_s <= write_enable;
    addr_s <= write_address;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clock_write);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("write_enable", 32'(we_s), 32'(e.we));
        if (e.we) chk("write_address", 32'(addr_s), 32'(e.addr));
        chk("gray", 32'(write_pointer_gray), 32'(e.gray));
        chk("level", 32'(write_level), 32'(e.lvl));
        chk("full", 32'(full), 32'(e.full));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("overflow", 32'(overflow_error), 32'(e.ovf));
        if (e.we && !e.rst) chk("gray_hamming", $countones(write_pointer_gray ^ prev_g), 1);
        prev_g = write_pointer_gray;
      end
    end
  end

  initial begin
    int rb, acc;
    repeat (2) step(0, 1, 0);
    for (int i = 0; i < 119; i++) step(1, 0, 0);
    after_edge();
    chk("af_119", 32'(almost_full), 0);
    step(1, 0, 0);
    after_edge();
    chk("af_120", 32'(almost_full), 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    after_edge();
    chk("full_128", 32'(full), 1);
    chk("gray_128", 32'(write_pointer_gray), 32'h0C0);
    chk("level_128", 32'(write_level), 128);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    after_edge();
    chk("ovf_set", 32'(overflow_error), 1);
    chk("gray_hold", 32'(write_pointer_gray), 32'h0C0);
    step(0, 0, 1);
    step(0, 0, 1);
    after_edge();
    chk("full_edge2", 32'(full), 1);
    step(0, 0, 1);
    after_edge();
    chk("full_edge3", 32'(full), 0);
    chk("level_edge3", 32'(write_level), 127);
    step(0, 0, 1);
    // long run across the 255->0 wrap with a trailing reader
    step(0, 1, 0);
    rb = 0;
    acc = 0;
    for (int i = 0; i < 1000 && acc < 300; i++) begin
      step(1, 0, rb);
      if (m_we) acc++;
      if (i % 4 != 0 && rb < acc) rb++;
    end
    chk("wrap_writes", acc, 300);
    // reset mid-fill with the request held
    step(0, 1, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 0);
    step(1, 1, 0);
    after_edge();
    chk("rst_level", 32'(write_level), 0);
    chk("rst_addr", 32'(write_address), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 0, 0);
    repeat (3) after_edge();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_write_control.md
FIFO_WRITE_CONTROL -- requirements
Module: fifo_write_control

Interface
REQ-001 The block SHALL have one parameter: ALMOST_FULL_THRESHOLD, default 120, fill level at or above which almost_full asserts (legal range 1..128).
REQ-002 The block SHALL have port clock_write, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_write, input, 1 bit: reset, synchronous to clock_write and active-high.
REQ-004 The block SHALL have port write_request, input, 1 bit: producer requests a write this cycle.
REQ-005 The block SHALL have port read_pointer_gray, input, 8 bits: Gray-coded read pointer from the read domain, asynchronous to clock_write.
REQ-006 The block SHALL have port write_enable, output, 1 bit: write accepted this cycle; drives the 128x16 memory write enable.
REQ-007 The block SHALL have port write_address, output, 7 bits: memory write location, equal to bits [6:0] of the binary write pointer.
REQ-008 The block SHALL have port write_pointer_gray, output, 8 bits: registered Gray-coded write pointer for the read domain.
REQ-009 The block SHALL have port full, output, 1 bit: registered full flag; also drives the memory full input.
REQ-010 The block SHALL have port almost_full, output, 1 bit: registered almost-full flag.
REQ-011 The block SHALL have port write_level, output, 8 bits: registered fill level, 0..128.
REQ-012 The block SHALL have port overflow_error, output, 1 bit: sticky flag for a write request while full.

Function
REQ-013 The block SHALL drive write_enable combinationally as write_request AND NOT full.
REQ-014 The block SHALL hold an 8-bit binary write pointer that increments by 1, modulo 256, on each clock_write edge with write_enable=1.
REQ-015 The block SHALL register write_pointer_gray as (next_bin >> 1) XOR next_bin, where next_bin is the binary pointer after this edge's increment; write_pointer_gray changes by exactly one bit per accepted write.
REQ-016 The block SHALL synchronize read_pointer_gray through two flops (sync1, sync2) clocked by clock_write; only sync2 is used by any logic.
REQ-017 The block SHALL convert sync2 from Gray to binary combinationally: bit 7 = g[7]; bit i = bin[i+1] XOR g[i].
REQ-018 The block SHALL register full <= (next_gray == {~sync2[7:6], sync2[5:0]}), so full asserts on the same edge as the 128th outstanding write.
REQ-019 The block SHALL register write_level <= (next_bin - read_bin_sync) modulo 256.
REQ-020 The block SHALL register almost_full <= (that same level >= ALMOST_FULL_THRESHOLD).
REQ-021 A read-pointer change SHALL reach full, almost_full and write_level within 3 clock_write edges: two synchronizer edges plus one flag register edge.
REQ-022 While full=1, write_request SHALL NOT change the pointers or the Gray output; that is the overflow boundary.
REQ-023 The block SHALL set overflow_error on an edge with write_request=1 and full=1; only reset clears it.
REQ-024 Pointer wrap from 255 to 0 SHALL be seamless: level, full and almost_full stay correct across the wrap.
REQ-025 When a write and a synchronized read-pointer change happen on the same edge, the block SHALL compute the flags from both new values.

Reset
REQ-026 On a clock_write edge with reset_write=1, the block SHALL set to 0: the binary pointer, write_pointer_gray, sync1, sync2, full, almost_full, write_level and overflow_error.
REQ-027 Reset SHALL override a simultaneous write_request; write_enable is still combinational, so the memory may take that one write, and the pointer discards it.
REQ-028 A reset during a fill SHALL return the block to empty with no residue of the previous state.

Verification
REQ-029 Bench scenario, reset then 128 consecutive writes, read_pointer_gray=0: write_address steps 0..127; full=1 right after the 128th edge; write_level=128; write_pointer_gray=8'hC0.
REQ-030 Bench scenario, while full, 3 more write_requests: write_enable=0, pointer stays at 128, overflow_error=1 and stays 1 until reset.
REQ-031 Bench scenario, ALMOST_FULL_THRESHOLD=120: almost_full=0 after 119 writes and =1 after the 120th edge.
REQ-032 Bench scenario, full with read_pointer_gray changed to 8'h01 (read bin 1): full=0 and write_level=127 by the 3rd edge after the change, and not earlier than the 2nd.
REQ-033 Bench scenario, 300 writes interleaved with a read model that advances the Gray pointer: no full or level mismatch across the 255->0 wrap; each write_pointer_gray step has Hamming distance 1.
REQ-034 Bench scenario, reset_write pulsed at write 50 with write_request held: the next cycle has pointer=0, write_level=0, full=0, overflow_error=0, and writes resume at address 0.
